custom_instr_initiator: RTL and testbench

CUSTOM_INSTR_INITIATOR -- requirements
Module: custom_instr_initiator

---
 rtl/custom_instr_initiator_pkg.sv | 31 +++
 rtl/ci_cmd_fifo.sv | 62 ++++++
 rtl/custom_instr_initiator.sv | 182 ++++++++++++++++++
 tb/tb_custom_instr_initiator.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_instr_initiator_pkg.sv
// -----------------------------------------------------------------------------
// custom_instr_initiator_pkg
// Shared definitions for the custom-instruction blocks:
//   FLT_DATA_WIDTH - default operand/result width
//   OP_*           - opcode values carried on cmd_n / ci_n
//   ST_*           - initiator FSM state encodings (also seen on dbg_state)
//   op_is_legal    - true for opcodes the receiver understands
// -----------------------------------------------------------------------------
package custom_instr_initiator_pkg;

   localparam int FLT_DATA_WIDTH = 32;

   // Opcodes understood by the receiver. Anything above OP_READ is illegal
   // and is answered locally with an error response.
   localparam logic [1:0] OP_CLEAR = 2'd0;
   localparam logic [1:0] OP_GO    = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;

   // Initiator FSM encodings.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_RESPOND = 2'd3;

   // The opcode is zero-extended by the caller so one function serves any
   // opcode width.
   function automatic logic op_is_legal(input logic [31:0] op);
      return (op == 32'(OP_CLEAR)) || (op == 32'(OP_GO)) || (op == 32'(OP_READ));
   endfunction

endpackage

// File: rtl/ci_cmd_fifo.sv
// -----------------------------------------------------------------------------
// ci_cmd_fifo
// Command queue for the custom-instruction initiator. Pointer-based FIFO with
// one extra wrap bit per pointer so full and empty are distinguishable.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (empties the queue)
//   push, wr_data - write one entry (ignored when full)
//   pop           - drop the head entry (ignored when empty)
//   rd_data       - head entry, valid while !empty
//   full, empty   - occupancy flags
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module ci_cmd_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage needs no reset: nothing is read while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/custom_instr_initiator.sv
// -----------------------------------------------------------------------------
// custom_instr_initiator
// Queues host commands and issues them one at a time to a custom-instruction
// receiver, returning exactly one response per accepted command, in order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and the payload must stay stable
// while valid is high and ready is low. This holds for cmd_* (host -> queue)
// and rsp_* (initiator -> host).
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   hold                     - host stall; gates ci_clk_en and freezes WAIT
//   cmd_valid/ready/n/a/b    - command input (opcode 0 CLEAR, 1 GO, 2 READ)
//   rsp_valid/ready/data/err - response output; err = timeout or bad opcode
//   ci_clk_en, ci_start      - receiver clock enable and one-cycle start
//   ci_n, ci_x_one, ci_x_two - opcode and operands, stable until done
//   ci_done, ci_result       - receiver completion and result
//   dbg_state                - current FSM state (ST_* encodings)
// -----------------------------------------------------------------------------
module custom_instr_initiator #(
   parameter int FLT_DATA_WIDTH = custom_instr_initiator_pkg::FLT_DATA_WIDTH,
   parameter int N_WIDTH        = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hold,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [N_WIDTH-1:0]        cmd_n,
   input  logic [FLT_DATA_WIDTH-1:0] cmd_a,
   input  logic [FLT_DATA_WIDTH-1:0] cmd_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [FLT_DATA_WIDTH-1:0] rsp_data,
   output logic                      rsp_err,
   output logic                      ci_clk_en,
   output logic                      ci_start,
   output logic [N_WIDTH-1:0]        ci_n,
   output logic [FLT_DATA_WIDTH-1:0] ci_x_one,
   output logic [FLT_DATA_WIDTH-1:0] ci_x_two,
   input  logic                      ci_done,
   input  logic [FLT_DATA_WIDTH-1:0] ci_result,
   output logic [1:0]                dbg_state
);

   import custom_instr_initiator_pkg::*;

   localparam int ENTRY_W = N_WIDTH + 2*FLT_DATA_WIDTH;
   localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   // Counter value during the last WAIT cycle allowed before timing out.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]                state;
   logic [1:0]                state_nxt;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic [ENTRY_W-1:0]        fifo_wr_data;
   logic [ENTRY_W-1:0]        fifo_rd_data;
   logic [N_WIDTH-1:0]        head_n;
   logic [FLT_DATA_WIDTH-1:0] head_a;
   logic [FLT_DATA_WIDTH-1:0] head_b;
   logic                      head_legal;
   logic                      illegal_q;
   logic [CNT_W-1:0]          wait_cnt;

   // ---------------------------------------------------------------------
   // Command queue
   // ---------------------------------------------------------------------
   // rst is folded in so the host sees no ready while reset is asserted.
   assign cmd_ready    = !fifo_full && !rst;
   assign fifo_push    = cmd_valid && cmd_ready;
   assign fifo_wr_data = {cmd_n, cmd_a, cmd_b};

   ci_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data (fifo_wr_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign {head_n, head_a, head_b} = fifo_rd_data;
   assign head_legal = op_is_legal(32'(head_n));

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   // ISSUE normally lasts one cycle. If hold rises during ISSUE the state is
   // kept so that the single ci_start pulse always coincides with
   // ci_clk_en = 1. Illegal opcodes never touch the receiver, so they leave
   // ISSUE immediately regardless of hold.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !hold) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (illegal_q)  state_nxt = ST_RESPOND;
            else if (!hold) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (!hold && (ci_done || (wait_cnt == CNT_LAST))) state_nxt = ST_RESPOND;
         end
         ST_RESPOND: begin
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign fifo_pop  = (state == ST_ISSUE) && (illegal_q || !hold);
   assign ci_start  = (state == ST_ISSUE) && !illegal_q && !hold;
   assign ci_clk_en = (((state == ST_ISSUE) && !illegal_q) || (state == ST_WAIT)) && !hold;
   assign rsp_valid = (state == ST_RESPOND);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         illegal_q <= 1'b0;
         ci_n      <= '0;
         ci_x_one  <= '0;
         ci_x_two  <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               // Operands are latched on entry to ISSUE, so they stay put
               // through ISSUE and WAIT even though the queue head moves on
               // when the entry is popped.
               if (!fifo_empty && !hold) begin
                  illegal_q <= !head_legal;
                  if (head_legal) begin
                     ci_n     <= head_n;
                     ci_x_one <= head_a;
                     ci_x_two <= head_b;
                  end
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               if (illegal_q) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            end
            ST_WAIT: begin
               // While held the counter freezes and ci_done is not looked at.
               if (!hold) begin
                  if (ci_done) begin
                     rsp_data <= ci_result;
                     rsp_err  <= 1'b0;
                  end else if (wait_cnt == CNT_LAST) begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_custom_instr_initiator.sv
module tb_custom_instr_initiator;
   import custom_instr_initiator_pkg::*;

   localparam int W = 32;

   // ------------------------------------------------------------------
   // Clock / reset and DUT signals
   // ------------------------------------------------------------------
   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          hold      = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_n     = '0;
   logic [W-1:0]  cmd_a     = '0;
   logic [W-1:0]  cmd_b     = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_data;
   logic          rsp_err;
   logic          ci_clk_en;
   logic          ci_start;
   logic [1:0]    ci_n;
   logic [W-1:0]  ci_x_one;
   logic [W-1:0]  ci_x_two;
   logic          ci_done;
   logic [W-1:0]  ci_result;
   logic [1:0]    dbg_state;

   int errors = 0;
   int checks = 0;
   logic [W:0] exp_q[$];

   always #5 clk = ~clk;

   custom_instr_initiator #(
      .FLT_DATA_WIDTH (W),
      .N_WIDTH        (2),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_n     (cmd_n),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ci_clk_en (ci_clk_en),
      .ci_start  (ci_start),
      .ci_n      (ci_n),
      .ci_x_one  (ci_x_one),
      .ci_x_two  (ci_x_two),
      .ci_done   (ci_done),
      .ci_result (ci_result),
      .dbg_state (dbg_state)
   );

   // ------------------------------------------------------------------
   // Receiver model: after a start it counts clock-enabled cycles and
   // raises done during the rcv_delay-th of them. Result is a+b unless a
   // fixed value is selected.
   // ------------------------------------------------------------------
   int         rcv_delay    = 1;
   bit         rcv_never    = 1'b0;
   bit         rcv_fixed_en = 1'b0;
   logic [W-1:0] rcv_fixed  = '0;
   logic       rcv_busy;
   int         rcv_cnt;
   int         start_cnt = 0;

   assign ci_done   = rcv_busy && !rcv_never && (rcv_cnt == rcv_delay);
   assign ci_result = rcv_fixed_en ? rcv_fixed : (ci_x_one + ci_x_two);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rcv_busy <= 1'b0;
         rcv_cnt  <= 0;
      end else if (ci_clk_en && ci_start) begin
         rcv_busy <= 1'b1;
         rcv_cnt  <= 1;
      end else if (rcv_busy && ci_clk_en) begin
         if (ci_done) rcv_busy <= 1'b0;
         else         rcv_cnt  <= rcv_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (ci_start && ci_clk_en) start_cnt <= start_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Driver tasks (called and returning at a negedge)
   // ------------------------------------------------------------------
   task automatic send_cmd(input logic [1:0] n, input logic [W-1:0] a, input logic [W-1:0] b,
                           output bit ok);
      int guard = 0;
      cmd_valid = 1'b1;
      cmd_n     = n;
      cmd_a     = a;
      cmd_b     = b;
      #1;
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      ok = cmd_ready;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int budget, output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
      checks++; if ({ci_start, ci_clk_en, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b expected 000", {ci_start, ci_clk_en, rsp_valid}); end
      checks++; if ({rsp_err, rsp_data} !== 33'h0) begin errors++; $display("FAIL rst_rsp: got %h expected 0", {rsp_err, rsp_data}); end
      checks++; if ({ci_n, ci_x_one, ci_x_two} !== 66'h0) begin errors++; $display("FAIL rst_ci_ops: got %h expected 0", {ci_n, ci_x_one, ci_x_two}); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_go();
      bit ok;
      int n_start = 0;
      int n_wait  = 0;
      int cyc     = 0;
      bit moved   = 1'b0;
      rcv_delay = 5; rcv_never = 1'b0; rcv_fixed_en = 1'b1; rcv_fixed = 32'h4040_0000; rsp_ready = 1'b1;
      send_cmd(OP_GO, 32'h3F80_0000, 32'h4000_0000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL go_accept: got %b expected 1", ok); end
      while (!rsp_valid && cyc < 50) begin
         if (ci_start) n_start++;
         else if (ci_clk_en) n_wait++;
         if ((ci_start || ci_clk_en) &&
             (ci_n !== OP_GO || ci_x_one !== 32'h3F80_0000 || ci_x_two !== 32'h4000_0000)) moved = 1'b1;
         @(negedge clk);
         cyc++;
      end
      checks++; if (n_start !== 1) begin errors++; $display("FAIL go_start_pulses: got %0d expected 1", n_start); end
      checks++; if (n_wait !== 5) begin errors++; $display("FAIL go_wait_cycles: got %0d expected 5", n_wait); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL go_operands_stable: got %b expected 0", moved); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL go_rsp_valid: got %b expected 1", rsp_valid); end
      checks++; if (rsp_data !== 32'h4040_0000) begin errors++; $display("FAIL go_rsp_data: got %h expected 40400000", rsp_data); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL go_rsp_err: got %b expected 0", rsp_err); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL go_respond_one_cycle: got %b expected 0", rsp_valid); end
      rcv_fixed_en = 1'b0;
   endtask

   task automatic test_latency();
      bit ok;
      int cyc;
      rcv_delay = 1; rsp_ready = 1'b1;
      send_cmd(OP_READ, 32'h10, 32'h20, ok);
      wait_rsp(20, cyc);
      // accept cycle, IDLE, ISSUE, WAIT -> rsp_valid four cycles after accept
      checks++; if (cyc !== 3) begin errors++; $display("FAIL latency_cycles: got %0d expected 3 after accept edge", cyc); end
      checks++; if ({rsp_err, rsp_data} !== {1'b0, 32'h30}) begin errors++; $display("FAIL latency_rsp: got %h expected 030", {rsp_err, rsp_data}); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n_rdy   = 0;
      int blocked = 0;
      int got     = 0;
      int cyc     = 0;
      logic [W:0] exp;
      rcv_delay = 2; rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_n     = OP_GO;
         cmd_a     = W'(32'h100 * (i + 1));
         cmd_b     = W'(i + 1);
         #1;
         if (cmd_ready) begin
            n_rdy++;
            exp_q.push_back({1'b0, W'(32'h101 * (i + 1))});
         end
         @(negedge clk);
      end
      // sixth command: 4 queued plus 1 in flight, must be refused
      cmd_a = 32'hDEAD;
      cmd_b = 32'h1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (cmd_ready !== 1'b0) blocked++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checks++; if (n_rdy !== 5) begin errors++; $display("FAIL b2b_accepted: got %0d expected 5", n_rdy); end
      checks++; if (blocked !== 0) begin errors++; $display("FAIL b2b_full_ready: got %0d ready cycles expected 0", blocked); end
      rsp_ready = 1'b1;
      while (got < 6 && cyc < 200) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b2b_extra_rsp: got %h expected no response", {rsp_err, rsp_data});
            end else begin
               exp = exp_q.pop_front();
               checks++; if ({rsp_err, rsp_data} !== exp) begin errors++; $display("FAIL b2b_rsp_%0d: got %h expected %h", got, {rsp_err, rsp_data}, exp); end
            end
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      checks++; if (got !== 5) begin errors++; $display("FAIL b2b_rsp_count: got %0d expected 5", got); end
      exp_q.delete();
   endtask

   task automatic test_timeout();
      bit ok;
      int n_wait = 0;
      int cyc    = 0;
      int s0;
      rcv_never = 1'b1; rsp_ready = 1'b1;
      send_cmd(OP_GO, 32'h1, 32'h2, ok);
      while (!rsp_valid && cyc < 60) begin
         if (ci_clk_en && !ci_start) n_wait++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (n_wait !== 16) begin errors++; $display("FAIL to_wait_cycles: got %0d expected 16", n_wait); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL to_rsp_valid: got %b expected 1", rsp_valid); end
      checks++; if ({rsp_err, rsp_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_rsp: got %h expected 100000000", {rsp_err, rsp_data}); end
      @(negedge clk);
      rcv_never = 1'b0; rcv_delay = 3;
      s0 = start_cnt;
      send_cmd(OP_GO, 32'h7, 32'h8, ok);
      wait_rsp(30, cyc);
      checks++; if ({rsp_err, rsp_data} !== {1'b0, 32'hF}) begin errors++; $display("FAIL to_next_rsp: got %h expected 00000000f", {rsp_err, rsp_data}); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL to_next_start: got %0d expected 1", start_cnt - s0); end
      @(negedge clk);
   endtask

   task automatic test_hold();
      bit ok;
      int unheld = 0;
      int held   = 0;
      int en_bad = 0;
      int cyc    = 0;
      rcv_delay = 12; rsp_ready = 1'b1;
      send_cmd(OP_GO, 32'h11, 32'h22, ok);
      while (!rsp_valid && cyc < 100) begin
         hold = (unheld == 3) && (held < 10);
         #1;
         if (hold) begin
            held++;
            if (dbg_state == ST_WAIT && ci_clk_en !== 1'b0) en_bad++;
         end else if (ci_clk_en && !ci_start) begin
            unheld++;
         end
         @(negedge clk);
         cyc++;
      end
      hold = 1'b0;
      checks++; if (held !== 10) begin errors++; $display("FAIL hold_cycles: got %0d expected 10", held); end
      checks++; if (en_bad !== 0) begin errors++; $display("FAIL hold_clk_en: got %0d enabled held cycles expected 0", en_bad); end
      checks++; if (unheld !== 12) begin errors++; $display("FAIL hold_unheld_wait: got %0d expected 12", unheld); end
      checks++; if ({rsp_err, rsp_data} !== {1'b0, 32'h33}) begin errors++; $display("FAIL hold_rsp: got %h expected 000000033", {rsp_err, rsp_data}); end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      bit ok;
      int cyc;
      int s0;
      rsp_ready = 1'b1;
      s0 = start_cnt;
      send_cmd(2'd3, 32'hAA, 32'hBB, ok);
      wait_rsp(10, cyc);
      checks++; if (rsp_valid !== 1'b1 || cyc > 2) begin errors++; $display("FAIL ill_latency: got valid=%b after %0d cycles expected valid within 2", rsp_valid, cyc); end
      checks++; if ({rsp_err, rsp_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ill_rsp: got %h expected 100000000", {rsp_err, rsp_data}); end
      checks++; if (start_cnt !== s0) begin errors++; $display("FAIL ill_no_start: got %0d starts expected 0", start_cnt - s0); end
      checks++; if (ci_x_one !== 32'h11) begin errors++; $display("FAIL ill_operands_untouched: got %h expected 00000011", ci_x_one); end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      bit ok;
      int seen = 0;
      int cyc;
      rcv_never = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_cmd(OP_GO, W'(32'h50 + i), W'(32'h60 + i), ok);
      end
      checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rmo_in_wait: got %0d expected %0d", dbg_state, ST_WAIT); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({cmd_ready, ci_start, ci_clk_en, rsp_valid, rsp_err} !== 5'b0) begin errors++; $display("FAIL rmo_ctrl: got %b expected 00000", {cmd_ready, ci_start, ci_clk_en, rsp_valid, rsp_err}); end
      checks++; if ({rsp_data, ci_n, ci_x_one, ci_x_two} !== 98'h0) begin errors++; $display("FAIL rmo_data: got %h expected 0", {rsp_data, ci_n, ci_x_one, ci_x_two}); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmo_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rcv_never = 1'b0; rcv_delay = 1;
      for (int i = 0; i < 30; i++) begin
         if (rsp_valid || ci_start) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rmo_no_rsp: got %0d active cycles expected 0", seen); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmo_ready: got %b expected 1", cmd_ready); end
      send_cmd(OP_CLEAR, 32'h5, 32'h6, ok);
      wait_rsp(20, cyc);
      checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'hB}) begin errors++; $display("FAIL rmo_after: got %h expected 20000000b", {rsp_valid, rsp_err, rsp_data}); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_go();
      test_latency();
      test_back_to_back();
      test_timeout();
      test_hold();
      test_illegal();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
